// File: rtl/scroll_if.sv
// Control/status bundle between the board switches/keys and the scroll sequencer.
// The master side drives the user controls; the slave side returns selector and status.
interface scroll_if;
    logic       DIR;
    logic       PAUSE;
    logic [1:0] SPEED;
    logic       STEP_N;
    logic [2:0] SELECTOR;
    logic       TICK;
    logic       RUNNING;

    modport master (output DIR, PAUSE, SPEED, STEP_N, input SELECTOR, TICK, RUNNING);
    modport slave  (input DIR, PAUSE, SPEED, STEP_N, output SELECTOR, TICK, RUNNING);
endinterface

// File: rtl/scroll_sequencer.sv
// Rotation-selector sequencer for the 8-digit HEX scroller: free-running scroll with
// four speeds, pause, and a debounced single-step button.
module scroll_sequencer #(
    parameter int unsigned BOUND_BASE = 18000000,
    parameter int unsigned DEBOUNCE   = 500000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic     CLOCK_50,
    input  logic     KEY0,
    scroll_if.slave  bus
);
    typedef enum logic [1:0] {ST_RUN, ST_PAUSED, ST_LOCK} state_t;

    localparam logic [CNT_W-1:0] BOUND    = CNT_W'(BOUND_BASE);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic             tick_q;
    logic             s1_q, s2_q, s3_q;
    logic             adv;
    logic             step_req;
    logic [CNT_W-1:0] period_m1;

    assign period_m1 = (BOUND >> bus.SPEED) - ONE;
    // Falling edge of the synchronised button, one flop behind the synchroniser output
    assign step_req  = s3_q & ~s2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adv     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.PAUSE) begin
                    state_d = ST_PAUSED;
                    cnt_d   = '0;
                end else if (cnt_q >= period_m1) begin
                    adv   = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_PAUSED: begin
                if (step_req) begin
                    adv     = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_LOCK;
                end else if (!bus.PAUSE) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_LOCK: begin
                // Leave only once the lockout has expired and the button is seen released
                if ((cnt_q >= DEB_LAST) && s2_q) begin
                    state_d = bus.PAUSE ? ST_PAUSED : ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q < DEB_LAST) begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sel_d = sel_q;
        if (adv) begin
            sel_d = bus.DIR ? (sel_q + 3'd1) : (sel_q - 3'd1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            sel_q   <= 3'd0;
            tick_q  <= 1'b0;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            s3_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            tick_q  <= adv;
            s1_q    <= bus.STEP_N;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
        end
    end

    assign bus.SELECTOR = sel_q;
    assign bus.TICK     = tick_q;
    assign bus.RUNNING  = (state_q == ST_RUN);
endmodule

// File: tb/tb_scroll_sequencer.sv
// Self-checking bench for scroll_sequencer with a behavioural model of the scroller.
module tb_scroll_sequencer;
    localparam int BB = 8;
    localparam int DB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    scroll_if bus();

    scroll_sequencer #(.BOUND_BASE(BB), .DEBOUNCE(DB), .CNT_W(8)) dut (
        .CLOCK_50 (clk),
        .KEY0     (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = scrolling, 1 = paused, 2 = lockout after a step
    int m_sel;
    bit m_tick;
    int m_mode;
    int m_elapsed;
    int m_age;
    bit m_h1, m_h2, m_h3;

    function automatic void model_reset();
        m_sel = 0; m_tick = 0; m_mode = 0; m_elapsed = 0; m_age = 0;
        m_h1 = 1; m_h2 = 1; m_h3 = 1;
    endfunction

    function automatic void model_edge();
        int p;
        bit adv;
        p   = BB >> bus.SPEED;
        adv = 0;
        if (m_mode == 0) begin
            if (bus.PAUSE) begin m_mode = 1; m_elapsed = 0; end
            else if (m_elapsed + 1 >= p) begin adv = 1; m_elapsed = 0; end
            else m_elapsed++;
        end else if (m_mode == 1) begin
            if (m_h3 && !m_h2) begin adv = 1; m_mode = 2; m_age = 0; end
            else if (!bus.PAUSE) begin m_mode = 0; m_elapsed = 0; end
        end else begin
            if (m_age >= DB - 1 && m_h2) begin m_mode = bus.PAUSE ? 1 : 0; m_elapsed = 0; end
            else m_age++;
        end
        if (adv) m_sel = (m_sel + (bus.DIR ? 1 : 7)) % 8;
        m_tick = adv;
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = bus.STEP_N;
    endfunction

    function automatic logic [4:0] mdl_vec();
        logic [31:0] s;
        s = m_sel;
        return {s[2:0], m_tick, (m_mode == 0)};
    endfunction

    function automatic logic [4:0] dut_vec();
        return {bus.SELECTOR, bus.TICK, bus.RUNNING};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.DIR = 1'b1; bus.PAUSE = 1'b0; bus.SPEED = 2'd0; bus.STEP_N = 1'b1;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec() !== 5'b000_0_1)
            $display("FAIL reset got=%b exp=%b", dut_vec(), 5'b000_0_1);
        if (dut_vec() !== 5'b000_0_1) errors++;
        rst_n = 1'b1;
    endtask

    task automatic test_scroll_up();
        bus.DIR = 1'b1; bus.SPEED = 2'd0; bus.PAUSE = 1'b0;
        do_reset();
        for (int i = 1; i <= 70; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL scroll_up cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
            if (i == 8 || i == 64) begin
                checks++;
                if (bus.SELECTOR !== ((i == 8) ? 3'd1 : 3'd0) || bus.TICK !== 1'b1) begin
                    errors++;
                    $display("FAIL scroll_up_point cyc=%0d got sel=%0d tick=%b", i, bus.SELECTOR, bus.TICK);
                end
            end
        end
    endtask

    task automatic test_scroll_down();
        bus.DIR = 1'b0; bus.SPEED = 2'd0; bus.PAUSE = 1'b0;
        do_reset();
        for (int i = 1; i <= 34; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL scroll_down cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
            if (i == 8 || i == 16 || i == 24 || i == 32) begin
                checks++;
                if (bus.TICK !== 1'b1 ||
                    bus.SELECTOR !== ((i == 8) ? 3'd7 : (i == 16) ? 3'd6 : (i == 24) ? 3'd5 : 3'd6)) begin
                    errors++;
                    $display("FAIL scroll_down_point cyc=%0d got sel=%0d tick=%b", i, bus.SELECTOR, bus.TICK);
                end
            end
            if (i == 28) bus.DIR = 1'b1;
        end
    endtask

    task automatic test_speed();
        bus.DIR = 1'b1; bus.SPEED = 2'd2; bus.PAUSE = 1'b0;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec() || bus.TICK !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL speed2 cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
        end
        bus.SPEED = 2'd0;
        do_reset();
        repeat (5) cycle();
        bus.SPEED = 2'd3;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec() || bus.SELECTOR !== 3'(i) || bus.TICK !== 1'b1) begin
                errors++;
                $display("FAIL speed_up cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_pause();
        bus.DIR = 1'b1; bus.SPEED = 2'd0; bus.PAUSE = 1'b0;
        do_reset();
        repeat (7) cycle();
        bus.PAUSE = 1'b1;
        cycle();
        checks++;
        if (dut_vec() !== 5'b000_0_0) begin
            errors++;
            $display("FAIL pause_due got=%b exp=%b", dut_vec(), 5'b000_0_0);
        end
        repeat (5) cycle();
        bus.PAUSE = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec() || bus.TICK !== (i == 9)) begin
                errors++;
                $display("FAIL resume cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_step();
        logic [9:0] pat;
        int ticks;
        bus.DIR = 1'b1; bus.SPEED = 2'd0; bus.PAUSE = 1'b0; bus.STEP_N = 1'b1;
        do_reset();
        repeat (32) cycle();
        bus.PAUSE = 1'b1;
        repeat (3) cycle();
        checks++;
        if (dut_vec() !== 5'b100_0_0) begin
            errors++;
            $display("FAIL step_setup got=%b exp=%b", dut_vec(), 5'b100_0_0);
        end
        pat   = 10'b00_0000_1010;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            bus.STEP_N = (i < 10) ? pat[i] : 1'b1;
            // Short glitch between clock edges as a third bounce
            if (i == 5) begin #1 bus.STEP_N = 1'b1; #1 bus.STEP_N = 1'b0; end
            cycle();
            ticks += int'(bus.TICK);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL step_bounce cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (ticks != 1 || bus.SELECTOR !== 3'd5) begin
            errors++;
            $display("FAIL step_once got ticks=%0d sel=%0d exp ticks=1 sel=5", ticks, bus.SELECTOR);
        end
        bus.STEP_N = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec() || bus.TICK !== (i == 3)) begin
                errors++;
                $display("FAIL step_second cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (bus.SELECTOR !== 3'd6 || bus.RUNNING !== 1'b0) begin
            errors++;
            $display("FAIL step_held got sel=%0d run=%b exp sel=6 run=0", bus.SELECTOR, bus.RUNNING);
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 5'b000_0_1) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", dut_vec(), 5'b000_0_1);
        end
        model_reset();
        bus.STEP_N = 1'b1;
        bus.PAUSE  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec() || bus.TICK !== (i == 8)) begin
                errors++;
                $display("FAIL after_reset cyc=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        bus.DIR = 1'b1; bus.SPEED = 2'd0; bus.PAUSE = 1'b0; bus.STEP_N = 1'b1;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) bus.DIR = ~bus.DIR;
            if ($urandom_range(0, 39) == 0) bus.SPEED = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) bus.PAUSE = ~bus.PAUSE;
            if ($urandom_range(0, 7) == 0) bus.STEP_N = ~bus.STEP_N;
            if ($urandom_range(0, 699) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                checks++;
                if (dut_vec() !== 5'b000_0_1) begin
                    errors++;
                    $display("FAIL rand_reset n=%0d got=%b", n, dut_vec());
                end
                model_reset();
                rst_n = 1'b1;
            end
            cycle();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random n=%0d got=%b exp=%b", n, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_scroll_up();
        test_scroll_down();
        test_speed();
        test_pause();
        test_step();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
